// File: rtl/frame_scheduler.sv
// Render-domain frame sequencer: syncs frame_pix, issues begin_frame/swap, tracks drops and offsets.
// begin_frame lands SYNC_STAGES+1 cycles after frame_pix is first sampled; a busy pipeline turns frame edges into drops.
module frame_scheduler #(
    parameter int                 FB_WIDTH    = 160,
    parameter int                 FB_HEIGHT   = 120,
    parameter logic signed [31:0] STEP_X      = 32'sh0000_8000,
    parameter logic signed [31:0] STEP_Y      = 32'sh0000_2000,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 ARM_CYCLES  = 8,
    parameter int                 CNT_W       = 16
) (
    input  logic                    clk_render,
    input  logic                    btn_rst_n,
    input  logic                    frame_pix,
    input  logic                    renderer_busy,
    input  logic                    feeder_busy,
    output logic                    begin_frame,
    output logic                    swap,
    output logic signed [31:0]      offset_x,
    output logic signed [31:0]      offset_y,
    output logic [CNT_W-1:0]        frame_count,
    output logic [CNT_W-1:0]        drop_count,
    output logic [1:0]              state_dbg
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RENDER = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic signed [31:0] X_BOUND = 32'(FB_WIDTH * 32768);
    localparam logic signed [31:0] Y_BOUND = 32'(FB_HEIGHT * 32768);
    localparam logic signed [31:0] X_START = -X_BOUND;
    localparam int                 ARM_W   = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0]   ARM_MAX = ARM_W'(ARM_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   frame_edge;
    logic [1:0]             state;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   done_now;

    // Registered edge detect supplies the extra cycle of frame_pix latency.
    always_ff @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            sync_q     <= '0;
            sync_prev  <= 1'b0;
            frame_edge <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], frame_pix};
            sync_prev  <= sync_q[SYNC_STAGES-1];
            frame_edge <= sync_q[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    assign done_now  = (arm_cnt >= ARM_MAX) && !renderer_busy && !feeder_busy;
    assign state_dbg = state;

    always_ff @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            state       <= ST_IDLE;
            arm_cnt     <= '0;
            begin_frame <= 1'b0;
            swap        <= 1'b0;
            offset_x    <= X_START;
            offset_y    <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            begin_frame <= 1'b0;
            swap        <= 1'b0;
            if (arm_cnt < ARM_MAX)
                arm_cnt <= arm_cnt + 1'b1;

            // Offsets advance as the begin_frame cycle closes, so they stay stable for the whole frame.
            if (begin_frame) begin
                frame_count <= frame_count + 1'b1;
                offset_x    <= (offset_x >= X_BOUND) ? X_START : offset_x + STEP_X;
                offset_y    <= (offset_y >= Y_BOUND) ? 32'sd0 : offset_y + STEP_Y;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_edge) begin
                        begin_frame <= 1'b1;
                        arm_cnt     <= '0;
                        state       <= ST_RENDER;
                    end
                end
                ST_RENDER: begin
                    if (frame_edge && done_now) begin
                        begin_frame <= 1'b1;
                        swap        <= 1'b1;
                        arm_cnt     <= '0;
                    end else if (frame_edge) begin
                        if (drop_count != '1)
                            drop_count <= drop_count + 1'b1;
                    end else if (done_now) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (frame_edge) begin
                        begin_frame <= 1'b1;
                        swap        <= 1'b1;
                        arm_cnt     <= '0;
                        state       <= ST_RENDER;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios plus randomized frames against a frame-level model.
module tb_frame_scheduler;
    localparam int XB   = 160 * 32768;
    localparam int YB   = 120 * 32768;
    localparam int SX   = 32'h8000;
    localparam int SY   = 32'h2000;
    localparam int PX   = (2 * XB) / SX + 1;
    localparam int PY   = YB / SY + 1;
    localparam int ARM  = 8;
    localparam int LAT  = 3;

    logic        clk_render = 1'b0;
    logic        btn_rst_n = 1'b0;
    logic        frame_pix = 1'b0;
    logic        renderer_busy = 1'b0;
    logic        feeder_busy = 1'b0;
    logic        begin_frame;
    logic        swap;
    logic [31:0] offset_x;
    logic [31:0] offset_y;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    frame_scheduler dut (
        .clk_render    (clk_render),
        .btn_rst_n     (btn_rst_n),
        .frame_pix     (frame_pix),
        .renderer_busy (renderer_busy),
        .feeder_busy   (feeder_busy),
        .begin_frame   (begin_frame),
        .swap          (swap),
        .offset_x      (offset_x),
        .offset_y      (offset_y),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .state_dbg     (state_dbg)
    );

    always #5 clk_render = ~clk_render;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Frame-level model: frame_pix samples in, "pipeline idle since frame start" as a sticky flag.
    bit [LAT:0] hist;
    bit         m_started, m_done, m_bf, m_sw;
    int         m_age, m_frames, m_drops;

    function automatic logic [31:0] exp_ox(input int f);
        return 32'(-XB + (f % PX) * SX);
    endfunction
    function automatic logic [31:0] exp_oy(input int f);
        return 32'((f % PY) * SY);
    endfunction

    always @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            hist = '0; m_started = 0; m_done = 0; m_bf = 0; m_sw = 0;
            m_age = 0; m_frames = 0; m_drops = 0;
        end else begin
            bit ev, bf_n, sw_n, done_now;
            if (m_bf) m_frames++;
            ev   = hist[LAT-1] & ~hist[LAT];
            hist = {hist[LAT-1:0], frame_pix};
            bf_n = 0; sw_n = 0;
            if (!m_started) begin
                if (ev) begin bf_n = 1; m_started = 1; m_age = 0; m_done = 0; end
            end else begin
                done_now = m_done || (m_age >= ARM && !renderer_busy && !feeder_busy);
                if (ev && done_now) begin
                    bf_n = 1; sw_n = 1; m_age = 0; m_done = 0;
                end else begin
                    if (ev && m_drops < 65535) m_drops++;
                    m_done = done_now;
                    m_age++;
                end
            end
            m_bf = bf_n;
            m_sw = sw_n;
        end
    end

    bit run_cmp = 0;
    always @(negedge clk_render) begin
        if (btn_rst_n && run_cmp) begin
            chk("m_begin_frame", begin_frame, m_bf);
            chk("m_swap", swap, m_sw);
            chk("m_offset_x", offset_x, exp_ox(m_frames));
            chk("m_offset_y", offset_y, exp_oy(m_frames));
            chk("m_frame_count", frame_count, m_frames & 32'hFFFF);
            chk("m_drop_count", drop_count, m_drops);
            chk("m_state", state_dbg, !m_started ? 32'd0 : (m_done ? 32'd2 : 32'd1));
        end
    end

    task automatic pulse(input int len);
        frame_pix = 1'b1;
        repeat (len) @(negedge clk_render);
        frame_pix = 1'b0;
    endtask

    task automatic wait_bf(input int lim);
        int n = 0;
        while (!begin_frame && n < lim) begin
            @(negedge clk_render);
            n++;
        end
        chk("bf_timeout", begin_frame, 1);
    endtask

    task automatic do_reset();
        @(negedge clk_render);
        #2 btn_rst_n = 1'b0;
        @(negedge clk_render);
        #2 btn_rst_n = 1'b1;
        @(negedge clk_render);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int bad;
        repeat (3) @(negedge clk_render);
        chk("rst_offset_x", offset_x, 32'hFFB0_0000);
        chk("rst_offset_y", offset_y, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_begin_frame", begin_frame, 0);
        #2 btn_rst_n = 1'b1;
        @(negedge clk_render);
        run_cmp = 1;

        // First frame: latency and offsets around the pulse.
        frame_pix = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_render);
            chk("lat_bf", begin_frame, (k == LAT) ? 1 : 0);
        end
        frame_pix = 1'b0;
        chk("first_swap", swap, 0);
        chk("first_ox_pulse", offset_x, 32'hFFB0_0000);
        renderer_busy = 1'b1;
        @(negedge clk_render);
        chk("first_ox_after", offset_x, 32'hFFB0_8000);
        chk("first_fc", frame_count, 1);

        // Renderer drains 20 cycles after begin_frame.
        repeat (18) @(negedge clk_render);
        renderer_busy = 1'b0;
        repeat (15) @(negedge clk_render);
        chk("done_state", state_dbg, 2);
        pulse(2);
        wait_bf(20);
        chk("swap_with_bf", swap, 1);
        chk("state_back_render", state_dbg, 1);
        chk("no_drop", drop_count, 0);

        // Three edges while busy are dropped.
        renderer_busy = 1'b1;
        repeat (3) begin
            pulse(2);
            repeat (12) @(negedge clk_render);
        end
        chk("drop3", drop_count, 3);
        renderer_busy = 1'b0;
        repeat (5) @(negedge clk_render);
        pulse(2);
        wait_bf(20);
        chk("swap_after_drops", swap, 1);

        // Idle before the arm window closes must not count as done.
        bad = 0;
        repeat (5) begin
            @(negedge clk_render);
            if (state_dbg != 2'd1) bad++;
        end
        renderer_busy = 1'b1;
        repeat (100) begin
            @(negedge clk_render);
            if (state_dbg != 2'd1) bad++;
        end
        chk("arm_no_early_done", bad, 0);

        // Asynchronous reset mid-frame.
        #2 btn_rst_n = 1'b0;
        #1;
        chk("mid_rst_bf", begin_frame, 0);
        chk("mid_rst_swap", swap, 0);
        chk("mid_rst_ox", offset_x, 32'hFFB0_0000);
        chk("mid_rst_fc", frame_count, 0);
        chk("mid_rst_dc", drop_count, 0);
        chk("mid_rst_state", state_dbg, 0);
        @(negedge clk_render);
        #2 btn_rst_n = 1'b1;
        renderer_busy = 1'b0;
        @(negedge clk_render);
        pulse(2);
        wait_bf(20);
        chk("post_rst_swap", swap, 0);

        // Randomized frames with random busy patterns.
        for (int f = 0; f < 200; f++) begin
            pulse($urandom_range(1, 4));
            repeat ($urandom_range(4, 30)) begin
                renderer_busy = ($urandom_range(0, 3) == 0);
                feeder_busy   = ($urandom_range(0, 5) == 0);
                @(negedge clk_render);
            end
        end
        renderer_busy = 1'b0;
        feeder_busy   = 1'b0;

        // Offset wrap points over 482 completed frames.
        do_reset();
        for (int n = 1; n <= 482; n++) begin
            pulse(1);
            wait_bf(10);
            if (n == 321) begin
                chk("ox_f321", offset_x, 32'h0050_0000);
                chk("model_ox_f321", exp_ox(m_frames), 32'h0050_0000);
            end
            if (n == 322) chk("ox_f322", offset_x, 32'hFFB0_0000);
            if (n == 481) chk("oy_f481", offset_y, 32'h003C_0000);
            if (n == 482) begin
                chk("oy_f482", offset_y, 0);
                chk("model_oy_f482", exp_oy(m_frames), 0);
            end
            repeat (12) @(negedge clk_render);
        end
        chk("fc_482", frame_count, 482);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Render-domain frame sequencer between the display timing generator and the render pipeline (triangle_feeder, render_manager, double_framebuffer).
- Synchronises the pixel-domain frame pulse and issues one begin_frame per rendered frame.
- Raises swap only when the previous frame has fully drained; counts dropped frames.
- Owns the per-frame animation offsets (offset_x/offset_y) fed to triangle_feeder.

Parameters:
FB_WIDTH, 160, framebuffer width in pixels; sets offset_x wrap bound
FB_HEIGHT, 120, framebuffer height in pixels; sets offset_y wrap bound
STEP_X, 32'sh0000_8000, q16.16 offset_x increment per frame
STEP_Y, 32'sh0000_2000, q16.16 offset_y increment per frame
SYNC_STAGES, 2, synchroniser flops on frame_pix (min 2)
ARM_CYCLES, 8, min cycles after begin_frame before idle detection is trusted
CNT_W, 16, width of frame_count and drop_count

Ports:
clk_render  in  1  render clock; frequency >= clk_pix
btn_rst_n  in  1  asynchronous, active-low reset
frame_pix  in  1  frame-start pulse from clk_pix domain (>= 1 clk_pix wide)
renderer_busy  in  1  render_manager busy
feeder_busy  in  1  triangle_feeder busy
begin_frame  out  1  one-cycle pulse: start feeder and render manager
swap  out  1  one-cycle pulse: swap double_framebuffer buffers
offset_x  out  32  signed q16.16 x offset for the current frame
offset_y  out  32  signed q16.16 y offset for the current frame
frame_count  out  CNT_W  begin_frame pulses issued (wraps)
drop_count  out  CNT_W  frame edges skipped while busy (saturates)
state_dbg  out  2  FSM state encoding

Behaviour:
- Reset is asynchronous on the falling edge of btn_rst_n. During reset:
  - begin_frame=0, swap=0.
  - offset_x = -(FB_WIDTH<<15), i.e. 0xFFB0_0000 at default; offset_y=0.
  - frame_count=0, drop_count=0, synchroniser flops=0, state=IDLE.
- Reset mid-frame aborts immediately; the first edge after release is handled as after power-up (no swap).
- Synchroniser: frame_pix passes through SYNC_STAGES flops plus an edge-detect flop. frame_edge = sync_last & ~sync_prev.
- Latency: begin_frame rises exactly SYNC_STAGES+1 clk_render cycles after the first clk_render edge that samples frame_pix high.
- FSM states:
  - IDLE (0): after reset only. On frame_edge, next cycle begin_frame=1, swap=0 → RENDER.
  - RENDER (1): arm counter cleared on begin_frame and counts to ARM_CYCLES, then holds. When arm counter >= ARM_CYCLES and renderer_busy=0 and feeder_busy=0 → DONE.
  - RENDER, frame_edge while not done: no pulse; drop_count += 1 (saturating at all-ones); remain in RENDER.
  - RENDER, frame_edge in the same cycle completion is detected: counts as completed. Next cycle begin_frame=1 and swap=1, stay in RENDER, arm counter reset; no drop.
  - DONE (2): on frame_edge, next cycle begin_frame=1 and swap=1 (same cycle) → RENDER.
  - Encoding 3 is unused and recovers to IDLE.
- begin_frame and swap are registered and never high for more than one cycle. swap is never asserted without begin_frame.
- frame_count increments in the cycle begin_frame is high and wraps modulo 2^CNT_W.
- Offsets are stable while begin_frame is high and throughout the frame; they update on the clock edge that ends the begin_frame cycle.
  - offset_x: if offset_x >= (FB_WIDTH<<15), then -(FB_WIDTH<<15); else offset_x + STEP_X. Signed 32-bit compare.
  - offset_y: if offset_y >= (FB_HEIGHT<<15), then 0; else offset_y + STEP_Y.
- Busy inputs are ignored in IDLE and DONE.

Test Plan:
- Reset release, frame_pix high for 4 cycles → single begin_frame pulse 3 cycles after first sampled high; swap=0; frame_count=1; offset_x=0xFFB0_0000 during the pulse, 0xFFB0_8000 one cycle later.
- Renderer drops busy 20 cycles after begin_frame, next frame_pix → begin_frame and swap high in the same cycle; state_dbg sequence 1→2→1; drop_count=0.
- Hold renderer_busy=1 across 3 frame_pix pulses → no begin_frame, no swap, drop_count=3. Release busy, then next pulse → begin_frame+swap.
- Busy low for the first 5 cycles after begin_frame (ARM_CYCLES=8), then high for 100 cycles → DONE not entered before cycle 105; no premature swap.
- 321 completed frames → offset_x reaches 0x0050_0000 at frame 321 and is 0xFFB0_0000 at frame 322. offset_y wraps from 0x003C_0000 to 0 after 481 steps.
- Assert btn_rst_n=0 mid-RENDER for 1 cycle → all outputs at reset values immediately. Next frame_pix → begin_frame with swap=0.
